// File: rtl/isqrt_pipe_pkg.sv
// isqrt_pipe_pkg: widths, per-stage record and the single-iteration
// restoring square-root step shared by every pipeline stage.
package isqrt_pipe_pkg;

    localparam int X_W   = 32;  // radicand width
    localparam int Y_W   = 16;  // root width, also the total iteration count
    localparam int REM_W = 18;  // partial remainder width (max 2*root+1 fits)

    typedef struct packed {
        logic             vld;
        logic [X_W-1:0]   radicand;  // unconsumed radicand bits, MSB-aligned
        logic [REM_W-1:0] rem;
        logic [Y_W-1:0]   root;
    } isqrt_stage_t;

    // One restoring iteration: bring down two radicand bits and try to
    // subtract (root<<2 | 1); keep the difference and set a root bit on success.
    function automatic isqrt_stage_t isqrt_iter(input isqrt_stage_t s);
        isqrt_stage_t     o;
        logic [REM_W+1:0] sh;
        logic [REM_W+1:0] sub;
        logic [REM_W+1:0] diff;
        o          = s;
        sh         = {s.rem, s.radicand[X_W-1 -: 2]};
        sub        = {2'b00, s.root, 2'b01};
        diff       = sh - sub;
        o.radicand = {s.radicand[X_W-3:0], 2'b00};
        if (sh >= sub) begin
            o.rem  = diff[REM_W-1:0];
            o.root = {s.root[Y_W-2:0], 1'b1};
        end else begin
            o.rem  = sh[REM_W-1:0];
            o.root = {s.root[Y_W-2:0], 1'b0};
        end
        return o;
    endfunction

endpackage

// File: rtl/isqrt_pipe_stage.sv
// isqrt_pipe_stage: ITERS combinational square-root iterations followed by
// one register. Valid is reset and shifts every cycle; data only loads when
// the incoming operand is valid so idle stages keep their old contents.
module isqrt_pipe_stage
    import isqrt_pipe_pkg::*;
#(
    parameter int ITERS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  isqrt_stage_t d,
    output isqrt_stage_t q
);

    isqrt_stage_t     nxt;
    logic             vld_q;
    logic [X_W-1:0]   rad_q;
    logic [REM_W-1:0] rem_q;
    logic [Y_W-1:0]   root_q;

    // Unrolled chain of iterations feeding this stage's register.
    always_comb begin
        nxt = d;
        for (int i = 0; i < ITERS; i++) begin
            nxt = isqrt_iter(nxt);
        end
    end

    // Valid shift with async clear so in-flight work is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= nxt.vld;
    end

    // Data capture gated by incoming valid; intentionally not reset.
    always_ff @(posedge clk) begin
        if (nxt.vld) begin
            rad_q  <= nxt.radicand;
            rem_q  <= nxt.rem;
            root_q <= nxt.root;
        end
    end

    assign q = '{vld: vld_q, radicand: rad_q, rem: rem_q, root: root_q};

endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined floor(sqrt(x)) for a 32-bit radicand, one
// operand per cycle, latency n_stages. Define ISQRT_PIPE_OCCUPANCY_EN to add
// the busy/occupancy ports and the in-flight counter behind them.
module isqrt_pipe
    import isqrt_pipe_pkg::*;
#(
    parameter int n_stages = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [X_W-1:0] x,
    output logic           y_vld,
    output logic [Y_W-1:0] y
`ifdef ISQRT_PIPE_OCCUPANCY_EN
    ,
    output logic           busy,
    output logic [4:0]     occupancy
`endif
);

    // Depth must split the 16 iterations evenly.
    if (n_stages < 1 || n_stages > Y_W || (Y_W % n_stages) != 0) begin : g_bad_depth
        $error("isqrt_pipe: n_stages=%0d must be one of 1, 2, 4, 8, 16", n_stages);
    end

    localparam int ITERS = Y_W / n_stages;

    isqrt_stage_t pipe [n_stages+1];
    logic         unused_tail;

    assign pipe[0] = '{vld: x_vld, radicand: x, rem: '0, root: '0};

    for (genvar g = 0; g < n_stages; g++) begin : g_stage
        isqrt_pipe_stage #(
            .ITERS (ITERS)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (pipe[g]),
            .q   (pipe[g+1])
        );
    end

    assign y_vld = pipe[n_stages].vld;
    assign y     = pipe[n_stages].root;

    // Radicand is fully consumed and the remainder is not exported.
    assign unused_tail = ^{pipe[n_stages].radicand, pipe[n_stages].rem};

`ifdef ISQRT_PIPE_OCCUPANCY_EN
    logic [4:0] occ_q;

    // In-flight count: +1 on accept, -1 on retire, hold when both or neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= 5'd0;
        end else begin
            case ({x_vld, y_vld})
                2'b10:   occ_q <= occ_q + 5'd1;
                2'b01:   occ_q <= occ_q - 5'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occupancy = occ_q;
    assign busy      = (occ_q != 5'd0);
`endif

endmodule
